// File: rtl/tpu_top.sv
`timescale 1ns/1ps
// tpu_top: APB-configured matrix-multiply tile engine with three single-port
// BRAMs (A, B, C). The host owns the BRAM ports while idle; the MAC engine
// owns them while busy.

// Single-port BRAM, per-element write mask, registered read (1-cycle latency).
module tpu_bram #(
  parameter int DWIDTH = 8,
  parameter int NELEM  = 4,
  parameter int AWIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AWIDTH-1:0]       i_addr,
  input  logic [NELEM*DWIDTH-1:0] i_wdata,
  input  logic [NELEM-1:0]        i_we,
  output logic [NELEM*DWIDTH-1:0] o_rdata
);
  logic [NELEM*DWIDTH-1:0] r_mem [2**AWIDTH];

  // Masked element writes into the storage array.
  // NOTE: the storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NELEM; k++) begin
      if (i_we[k]) r_mem[i_addr][k*DWIDTH +: DWIDTH] <= i_wdata[k*DWIDTH +: DWIDTH];
    end
  end

  // Read data register; old data is returned on a simultaneous write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) o_rdata <= '0;
    else       o_rdata <= r_mem[i_addr];
  end
endmodule

module tpu_top #(
  parameter int DWIDTH        = 8,
  parameter int MAT_MUL_SIZE  = 4,
  parameter int AWIDTH        = 10,
  parameter int MASK_WIDTH    = 4,
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [REG_ADDRWIDTH-1:0]       PADDR,
  input  logic                           PWRITE,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic [REG_DATAWIDTH-1:0]       PWDATA,
  output logic [REG_DATAWIDTH-1:0]       PRDATA,
  output logic                           PREADY,
  input  logic [AWIDTH-1:0]              bram_addr_a_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_a_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_a_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_a_ext,
  input  logic [AWIDTH-1:0]              bram_addr_b_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_b_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_b_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_b_ext,
  input  logic [AWIDTH-1:0]              bram_addr_c_ext,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_c_ext,
  input  logic [MASK_WIDTH-1:0]          bram_we_c_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_rdata_c_ext
);
  localparam int N    = MAT_MUL_SIZE;
  localparam int WW   = N * DWIDTH;
  localparam int CW   = $clog2(N);
  localparam int SUMW = 2 * DWIDTH + CW + 1;  // full dot product plus old C
  localparam logic [SUMW-1:0] SAT = {{(SUMW-DWIDTH){1'b0}}, {DWIDTH{1'b1}}};

  localparam logic [REG_ADDRWIDTH-1:0] ADDR_CTRL   = 'h00;
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_STATUS = 'h04;
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_BASE_A = 'h08;
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_BASE_B = 'h0C;
  localparam logic [REG_ADDRWIDTH-1:0] ADDR_BASE_C = 'h10;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_B, S_READ_ROW, S_COMPUTE, S_WRITE, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic                     r_accum_cfg, r_accum_run, r_done, r_host_q;
  logic [AWIDTH-1:0]        r_base_a, r_base_b, r_base_c;
  logic [REG_DATAWIDTH-1:0] r_prdata, w_rd_val;
  logic [CW:0]              r_cnt;
  logic [CW-1:0]            r_row, w_b_idx;
  logic [N-1:0][WW-1:0]     r_brow;
  logic [WW-1:0]            r_crow, w_crow_next;
  logic [SUMW-1:0]          w_sum;
  logic [N-1:0]             w_we_c_eng;
  logic                     w_busy, w_apb_wr, w_apb_rd, w_start, w_unused;

  logic [AWIDTH-1:0] w_addr_a, w_addr_b, w_addr_c;
  logic [WW-1:0]     w_q_a, w_q_b, w_q_c, w_wdata_c;
  logic [N-1:0]      w_we_a, w_we_b, w_we_c;

  assign w_busy   = (r_state != S_IDLE);
  assign w_apb_wr = PSEL & PENABLE & PWRITE;
  assign w_apb_rd = PSEL & PENABLE & ~PWRITE;
  assign w_start  = w_apb_wr && (PADDR == ADDR_CTRL) && PWDATA[0] && !w_busy;
  assign w_b_idx  = CW'(r_cnt - 1'b1);
  assign w_unused = ^PWDATA[REG_DATAWIDTH-1:AWIDTH];
  assign PREADY   = PSEL & PENABLE;
  assign PRDATA   = r_prdata;

  // Configuration registers, start handshake and sticky done flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_accum_cfg <= 1'b0;
      r_accum_run <= 1'b0;
      r_done      <= 1'b0;
      r_base_a    <= '0;
      r_base_b    <= '0;
      r_base_c    <= '0;
    end else begin
      if (w_apb_wr) begin
        case (PADDR)
          ADDR_CTRL:   r_accum_cfg <= PWDATA[1];
          ADDR_BASE_A: r_base_a    <= PWDATA[AWIDTH-1:0];
          ADDR_BASE_B: r_base_b    <= PWDATA[AWIDTH-1:0];
          ADDR_BASE_C: r_base_c    <= PWDATA[AWIDTH-1:0];
          default: ;
        endcase
      end
      if (w_start) begin
        r_accum_run <= PWDATA[1];
        r_done      <= 1'b0;
      end else if (r_state == S_DONE) begin
        r_done <= 1'b1;
      end
    end
  end

  // APB read decode; unmapped addresses and unused bits read as zero.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_rd_val = '0;
    case (PADDR)
      ADDR_CTRL:   w_rd_val[1] = r_accum_cfg;
      ADDR_STATUS: begin
        w_rd_val[0] = r_done;
        w_rd_val[1] = w_busy;
      end
      ADDR_BASE_A: w_rd_val[AWIDTH-1:0] = r_base_a;
      ADDR_BASE_B: w_rd_val[AWIDTH-1:0] = r_base_b;
      ADDR_BASE_C: w_rd_val[AWIDTH-1:0] = r_base_c;
      default: ;
    endcase
  end

  // PRDATA holds the last read until the next read access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_prdata <= '0;
    else if (w_apb_rd) r_prdata <= w_rd_val;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // FSM next-state and engine write strobe.
  always_comb begin
    w_next     = r_state;
    w_we_c_eng = '0;
    case (r_state)
      S_IDLE:     if (w_start) w_next = S_LOAD_B;
      S_LOAD_B:   if (r_cnt == (CW+1)'(N)) w_next = S_READ_ROW;
      S_READ_ROW: w_next = S_COMPUTE;
      S_COMPUTE:  w_next = S_WRITE;
      S_WRITE: begin
        w_we_c_eng = '1;
        w_next     = (r_row == CW'(N-1)) ? S_DONE : S_READ_ROW;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Engine counters, cached B matrix and computed C row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_row  <= '0;
      r_brow <= '0;
      r_crow <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_row <= '0;
        end
        S_LOAD_B: begin
          r_cnt <= r_cnt + 1'b1;
          // read data trails the issued address by one cycle
          if (r_cnt != '0) r_brow[w_b_idx] <= w_q_b;
        end
        S_COMPUTE: r_crow <= w_crow_next;
        S_WRITE:   r_row  <= r_row + 1'b1;
        default: ;
      endcase
    end
  end

  // One row of C: full-width dot products, optional accumulate, saturate.
  always_comb begin
    w_sum       = '0;
    w_crow_next = '0;
    for (int j = 0; j < N; j++) begin
      w_sum = r_accum_run ? SUMW'(w_q_c[j*DWIDTH +: DWIDTH]) : '0;
      for (int k = 0; k < N; k++) begin
        w_sum = w_sum + SUMW'(w_q_a[k*DWIDTH +: DWIDTH]) * SUMW'(r_brow[k][j*DWIDTH +: DWIDTH]);
      end
      w_crow_next[j*DWIDTH +: DWIDTH] = (w_sum > SAT) ? {DWIDTH{1'b1}} : w_sum[DWIDTH-1:0];
    end
  end

  // Port ownership: engine while busy (host writes dropped), host otherwise.
  assign w_addr_a  = w_busy ? r_base_a + AWIDTH'(r_row)          : bram_addr_a_ext;
  assign w_addr_b  = w_busy ? r_base_b + AWIDTH'(r_cnt[CW-1:0])  : bram_addr_b_ext;
  assign w_addr_c  = w_busy ? r_base_c + AWIDTH'(r_row)          : bram_addr_c_ext;
  assign w_we_a    = w_busy ? '0         : bram_we_a_ext;
  assign w_we_b    = w_busy ? '0         : bram_we_b_ext;
  assign w_we_c    = w_busy ? w_we_c_eng : bram_we_c_ext;
  assign w_wdata_c = w_busy ? r_crow     : bram_wdata_c_ext;

  // Tracks whether the data in the read registers belongs to the host.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_host_q <= 1'b0;
    else       r_host_q <= ~w_busy;
  end

  assign bram_rdata_a_ext = r_host_q ? w_q_a : '0;
  assign bram_rdata_b_ext = r_host_q ? w_q_b : '0;
  assign bram_rdata_c_ext = r_host_q ? w_q_c : '0;

  tpu_bram #(.DWIDTH(DWIDTH), .NELEM(N), .AWIDTH(AWIDTH)) u_bram_a (
    .clk(clk), .reset(reset), .i_addr(w_addr_a), .i_wdata(bram_wdata_a_ext),
    .i_we(w_we_a), .o_rdata(w_q_a));
  tpu_bram #(.DWIDTH(DWIDTH), .NELEM(N), .AWIDTH(AWIDTH)) u_bram_b (
    .clk(clk), .reset(reset), .i_addr(w_addr_b), .i_wdata(bram_wdata_b_ext),
    .i_we(w_we_b), .o_rdata(w_q_b));
  tpu_bram #(.DWIDTH(DWIDTH), .NELEM(N), .AWIDTH(AWIDTH)) u_bram_c (
    .clk(clk), .reset(reset), .i_addr(w_addr_c), .i_wdata(w_wdata_c),
    .i_we(w_we_c), .o_rdata(w_q_c));
endmodule

// File: tb/tb_tpu_top.sv
`timescale 1ns/1ps
// tb_tpu_top: directed scenarios for the tpu_top matrix-multiply tile engine.
module tb_tpu_top;
  localparam logic [7:0] A_CTRL = 8'h00, A_STATUS = 8'h04;
  localparam logic [7:0] A_BA = 8'h08, A_BB = 8'h0C, A_BC = 8'h10;
  localparam logic [31:0] B0 = 32'h04030201, B1 = 32'h08070605;
  localparam logic [31:0] B2 = 32'h0C0B0A09, B3 = 32'h100F0E0D;
  localparam logic [31:0] I0 = 32'h00000001, I1 = 32'h00000100;
  localparam logic [31:0] I2 = 32'h00010000, I3 = 32'h01000000;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  paddr;
  logic        pwrite, psel, penable, pready;
  logic [31:0] pwdata, prdata;
  logic [9:0]  addr_a, addr_b, addr_c;
  logic [31:0] wd_a, wd_b, wd_c, rd_a, rd_b, rd_c;
  logic [3:0]  we_a, we_b, we_c;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tpu_top dut (
    .clk(clk), .reset(reset),
    .PADDR(paddr), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
    .PWDATA(pwdata), .PRDATA(prdata), .PREADY(pready),
    .bram_addr_a_ext(addr_a), .bram_wdata_a_ext(wd_a), .bram_we_a_ext(we_a), .bram_rdata_a_ext(rd_a),
    .bram_addr_b_ext(addr_b), .bram_wdata_b_ext(wd_b), .bram_we_b_ext(we_b), .bram_rdata_b_ext(rd_b),
    .bram_addr_c_ext(addr_c), .bram_wdata_c_ext(wd_c), .bram_we_c_ext(we_c), .bram_rdata_c_ext(rd_c));

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); psel = 1; pwrite = 1; paddr = a; pwdata = d; penable = 0;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); psel = 1; pwrite = 0; paddr = a; penable = 0;
    @(negedge clk); penable = 1;
    @(posedge clk); #1 d = prdata;
    @(negedge clk); psel = 0; penable = 0;
  endtask

  task automatic host_write(input int id, input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    case (id)
      0: begin addr_a = a; wd_a = d; we_a = m; end
      1: begin addr_b = a; wd_b = d; we_b = m; end
      default: begin addr_c = a; wd_c = d; we_c = m; end
    endcase
    @(negedge clk); we_a = 0; we_b = 0; we_c = 0;
  endtask

  task automatic host_read(input int id, input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    case (id)
      0: addr_a = a;
      1: addr_b = a;
      default: addr_c = a;
    endcase
    @(posedge clk); #1;
    case (id)
      0: d = rd_a;
      1: d = rd_b;
      default: d = rd_c;
    endcase
  endtask

  task automatic preload(input int id, input logic [9:0] base,
                         input logic [31:0] r0, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] r3);
    host_write(id, base,        r0, 4'hF);
    host_write(id, base + 10'd1, r1, 4'hF);
    host_write(id, base + 10'd2, r2, 4'hF);
    host_write(id, base + 10'd3, r3, 4'hF);
  endtask

  // Polls STATUS until done; lat = cycles since t0, or -1 if the bound expired.
  task automatic wait_done(input int t0, output int lat);
    logic [31:0] s;
    lat = -1;
    while (cyc - t0 <= 45) begin
      apb_read(A_STATUS, s);
      if (s[0]) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    #1;
    n_vec++; if ({rd_a, rd_b, rd_c} !== 96'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", {rd_a, rd_b, rd_c}); end
    n_vec++; if ({prdata, pready} !== 33'h0) begin n_err++; $display("FAIL reset_apb_out: got %h expected 0", {prdata, pready}); end
    @(negedge clk); reset = 0;
    apb_read(A_STATUS, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 0", d); end
    apb_read(A_CTRL, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_ctrl: got %h expected 0", d); end
  endtask

  task automatic test_apb_regs();
    logic [31:0] d;
    apb_write(A_BA, 32'h10); apb_write(A_BB, 32'h20); apb_write(A_BC, 32'h30);
    apb_read(A_BA, d); n_vec++; if (d !== 32'h10) begin n_err++; $display("FAIL addr_a_rb: got %h expected 10", d); end
    apb_read(A_BB, d); n_vec++; if (d !== 32'h20) begin n_err++; $display("FAIL addr_b_rb: got %h expected 20", d); end
    apb_read(A_BC, d); n_vec++; if (d !== 32'h30) begin n_err++; $display("FAIL addr_c_rb: got %h expected 30", d); end
    apb_write(8'h40, 32'hFFFFFFFF);
    apb_read(8'h40, d); n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_rd: got %h expected 0", d); end
    apb_write(A_BA, 32'hFFFFF3FF);
    apb_read(A_BA, d); n_vec++; if (d !== 32'h3FF) begin n_err++; $display("FAIL addr_a_upper: got %h expected 3ff", d); end
    apb_write(A_BA, 32'h10);
    apb_write(A_CTRL, 32'h2);
    apb_read(A_CTRL, d); n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL ctrl_accum_rb: got %h expected 2", d); end
    apb_write(A_CTRL, 32'h0);
    @(negedge clk); psel = 1; penable = 1; pwrite = 0; paddr = A_STATUS; #1;
    n_vec++; if (pready !== 1'b1) begin n_err++; $display("FAIL pready_access: got %b expected 1", pready); end
    @(negedge clk); psel = 0; penable = 0; #1;
    n_vec++; if (pready !== 1'b0) begin n_err++; $display("FAIL pready_idle: got %b expected 0", pready); end
  endtask

  task automatic test_host_mask();
    logic [31:0] d;
    host_write(2, 10'h100, 32'hAABBCCDD, 4'hF);
    host_write(2, 10'h100, 32'h11223344, 4'b0101);
    host_read(2, 10'h100, d);
    n_vec++; if (d !== 32'hAA22CC44) begin n_err++; $display("FAIL host_mask: got %h expected aa22cc44", d); end
  endtask

  // Runs one tile and compares the four C rows at base_c against exp.
  task automatic run_and_check(input string nm, input logic [31:0] ctrl, input logic [9:0] base_c,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] d, exp_row [4];
    int t0, lat;
    exp_row = '{e0, e1, e2, e3};
    apb_write(A_CTRL, ctrl); t0 = cyc;
    wait_done(t0, lat);
    n_vec++; if (lat < 0 || lat > 40) begin n_err++; $display("FAIL %s_latency: got %0d expected <=40", nm, lat); end
    apb_read(A_STATUS, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL %s_status: got %h expected 1", nm, d); end
    for (int r = 0; r < 4; r++) begin
      host_read(2, base_c + 10'(r), d);
      n_vec++; if (d !== exp_row[r]) begin n_err++; $display("FAIL %s_row%0d: got %h expected %h", nm, r, d, exp_row[r]); end
    end
  endtask

  task automatic test_identity();
    preload(0, 10'h10, I0, I1, I2, I3);
    preload(1, 10'h20, B0, B1, B2, B3);
    preload(2, 10'h30, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_and_check("identity", 32'h1, 10'h30, B0, B1, B2, B3);
  endtask

  task automatic test_accumulate();
    preload(2, 10'h30, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    preload(1, 10'h20, 32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
    run_and_check("accum", 32'h3, 10'h30, 32'h03030303, 32'h03030303, 32'h03030303, 32'h03030303);
  endtask

  task automatic test_saturation_and_wrap();
    preload(0, 10'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    preload(1, 10'h20, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_and_check("sat", 32'h1, 10'h30, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // C base near the top of the BRAM so rows 2 and 3 wrap to 0x000/0x001
    preload(0, 10'h10, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    preload(1, 10'h20, 32'h03030303, 32'h03030303, 32'h03030303, 32'h03030303);
    apb_write(A_BC, 32'h3FE);
    run_and_check("wrap", 32'h1, 10'h3FE, 32'h0C0C0C0C, 32'h0C0C0C0C, 32'h0C0C0C0C, 32'h0C0C0C0C);
    apb_write(A_BC, 32'h30);
  endtask

  task automatic test_busy();
    logic [31:0] d, exp_row [4];
    int t0, lat;
    exp_row = '{B0, B1, B2, B3};
    preload(0, 10'h10, I0, I1, I2, I3);
    preload(1, 10'h20, B0, B1, B2, B3);
    preload(2, 10'h30, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    host_write(2, 10'h200, 32'h55555555, 4'hF);
    apb_write(A_CTRL, 32'h1); t0 = cyc;
    apb_read(A_STATUS, d);
    n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL busy_status: got %h expected 2", d); end
    host_read(0, 10'h10, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL busy_rdata: got %h expected 0", d); end
    apb_write(A_CTRL, 32'h3);
    host_write(2, 10'h200, 32'hDEADBEEF, 4'hF);
    wait_done(t0, lat);
    n_vec++; if (lat < 0 || lat > 40) begin n_err++; $display("FAIL busy_latency: got %0d expected <=40", lat); end
    for (int r = 0; r < 4; r++) begin
      host_read(2, 10'h30 + 10'(r), d);
      n_vec++; if (d !== exp_row[r]) begin n_err++; $display("FAIL busy_row%0d: got %h expected %h", r, d, exp_row[r]); end
    end
    host_read(2, 10'h200, d);
    n_vec++; if (d !== 32'h55555555) begin n_err++; $display("FAIL busy_host_wr: got %h expected 55555555", d); end
    repeat (30) @(posedge clk);
    apb_read(A_STATUS, d);
    n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL busy_done_once: got %h expected 1", d); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    preload(2, 10'h30, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE);
    apb_write(A_CTRL, 32'h1);
    repeat (4) @(posedge clk);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    apb_read(A_STATUS, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midreset_status: got %h expected 0", d); end
    apb_read(A_BA, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL midreset_addr_a: got %h expected 0", d); end
    host_write(0, 10'h300, 32'h12345678, 4'hF);
    host_read(0, 10'h300, d);
    n_vec++; if (d !== 32'h12345678) begin n_err++; $display("FAIL midreset_host: got %h expected 12345678", d); end
    apb_write(A_BA, 32'h10); apb_write(A_BB, 32'h20); apb_write(A_BC, 32'h30);
    run_and_check("restart", 32'h1, 10'h30, B0, B1, B2, B3);
  endtask

  initial begin
    reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    addr_a = '0; addr_b = '0; addr_c = '0; wd_a = '0; wd_b = '0; wd_c = '0;
    we_a = '0; we_b = '0; we_c = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_apb_regs();
    test_host_mask();
    test_identity();
    test_accumulate();
    test_saturation_and_wrap();
    test_busy();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
